// File: rtl/acc_cpu_pkg.sv
// Shared types and defaults for the accumulator CPU: opcodes, FSM states,
// ALU operations and SKIP condition codes.
package acc_cpu_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_RESET_PC   = 'h100;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_NOT   = 4'h7,
    OP_ILL   = 4'h8,
    OP_SKIP  = 4'h9,
    OP_JUMP  = 4'hA,
    OP_CLEAR = 4'hB,
    OP_MUL   = 4'hC,
    OP_LOADI = 4'hD,
    OP_JUMPI = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IND, S_OPER, S_EXEC, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_MUL
  } alu_op_e;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  function automatic alu_op_e alu_op_of(opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_MUL:  return ALU_MUL;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU; PASS forwards the memory operand (LOAD/LOADI).
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_NOT:  y_o = ~a_i;
      ALU_MUL:  y_o = a_i * b_i;
      default:  y_o = b_i;
    endcase
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with a req/ack memory port.
//   state  | meaning
//   FETCH  | read instruction at pc, pc+1 on ack
//   DECODE | pick next state from opcode
//   IND    | read pointer word M[X] (LOADI/JUMPI)
//   OPER   | read or write operand
//   EXEC   | update ac/pc, retire
//   HALT   | absorbing stop state
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  illegal,
  output logic                  retire
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] ir_q, ac_q, md_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  halted_q, illegal_q, retire_q;

  opcode_e               op;
  logic [ADDR_WIDTH-1:0] x;
  logic                  ack;
  logic                  skip_take;
  logic [DATA_WIDTH-1:0] alu_y;

  assign op  = opcode_e'(ir_q[DATA_WIDTH-1 -: 4]);
  assign x   = ir_q[ADDR_WIDTH-1:0];
  assign ack = mem_req & mem_ack;

  acc_alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .op_i (alu_op_of(op)),
    .a_i  (ac_q),
    .b_i  (md_q),
    .y_o  (alu_y)
  );

  always_comb begin
    skip_take = 1'b0;
    case (ir_q[11:10])
      SKIP_NEG:   skip_take = ac_q[DATA_WIDTH-1];
      SKIP_ZERO:  skip_take = (ac_q == '0);
      SKIP_POS:   skip_take = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      SKIP_NEVER: skip_take = 1'b0;
      default:    skip_take = 1'b0;
    endcase
  end

  // Request is decoded from the held state so it stays stable across waits;
  // gating with rst_n drops it immediately when reset is applied.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH: mem_req = rst_n;
      S_IND: begin
        mem_req  = rst_n;
        mem_addr = x;
      end
      S_OPER: begin
        mem_req  = rst_n;
        mem_we   = rst_n && (op == OP_STORE);
        mem_addr = (op == OP_LOADI) ? md_q[ADDR_WIDTH-1:0] : x;
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign mem_wdata = ac_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_WIDTH'(RESET_PC);
      ac_q      <= '0;
      ir_q      <= '0;
      md_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: if (ack) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_WIDTH'(1);
          state_q <= S_DECODE;
        end
        S_DECODE: case (op)
          OP_LOADI, OP_JUMPI: state_q <= S_IND;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL:
            state_q <= S_OPER;
          OP_HALT: begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            retire_q <= 1'b1;
          end
          OP_ILL: begin
            state_q   <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            pc_q      <= pc_q - ADDR_WIDTH'(1);
          end
          default: begin
            state_q  <= S_EXEC;
            retire_q <= 1'b1;
          end
        endcase
        S_IND: if (ack) begin
          md_q <= mem_rdata;
          if (op == OP_LOADI) begin
            state_q <= S_OPER;
          end else begin
            state_q  <= S_EXEC;
            retire_q <= 1'b1;
          end
        end
        S_OPER: if (ack) begin
          md_q     <= mem_rdata;
          state_q  <= S_EXEC;
          retire_q <= 1'b1;
        end
        S_EXEC: begin
          case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_MUL, OP_LOADI:
              ac_q <= alu_y;
            OP_CLEAR: ac_q <= '0;
            OP_JUMP:  pc_q <= x;
            OP_JUMPI: pc_q <= md_q[ADDR_WIDTH-1:0];
            OP_SKIP:  if (skip_take) pc_q <= pc_q + ADDR_WIDTH'(1);
            default:  ;
          endcase
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign pc      = pc_q;
  assign ac      = ac_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retire  = retire_q;

endmodule
